// File: rtl/lot_controller.sv
// Parking-lot entry controller: round-robin gate arbitration for two entry
// lanes plus a clamped occupancy counter with saturation/tailgate reporting.
module lot_controller #(
  parameter int unsigned CAPACITY    = 255,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned GATE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [1:0]       inc,
  input  logic             dec,
  input  logic             clear,
  output logic [1:0]       gate_open,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             timeout,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, OPEN, CLOSE} state_t;

  localparam int unsigned TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(GATE_CYCLES - 1);
  localparam int unsigned SW = CNT_W + 2;
  localparam logic [SW-1:0] CAP_W = SW'(CAPACITY);
  localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);

  state_t        state;
  logic          ptr;
  logic          grant;
  logic [TW-1:0] timer;
  logic [1:0]    rst_sync;
  logic          run;
  logic          pick;

  logic [SW-1:0]    sum;
  logic [CNT_W-1:0] cnt_nxt;
  logic             clamp;
  logic             tail;

  // Reset asserts asynchronously but is released only after two clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run  = rst_sync[1];
  assign pick = req[ptr] ? ptr : ~ptr;

  // Two's-complement sum; the top bit flags an underflow below zero.
  always_comb begin
    sum     = {2'b00, count} + SW'(inc[0]) + SW'(inc[1]) - SW'(dec);
    cnt_nxt = sum[CNT_W-1:0];
    clamp   = 1'b0;
    if (sum[SW-1]) begin
      cnt_nxt = '0;
      clamp   = 1'b1;
    end else if (sum > CAP_W) begin
      cnt_nxt = CAP_C;
      clamp   = 1'b1;
    end
    tail = |(inc & ~gate_open);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      err   <= 1'b0;
    end else if (run) begin
      if (clear) begin
        count <= '0;
        full  <= 1'b0;
        empty <= 1'b1;
        err   <= 1'b0;
      end else begin
        count <= cnt_nxt;
        full  <= (cnt_nxt == CAP_C);
        empty <= (cnt_nxt == '0);
        err   <= clamp | tail;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      grant     <= 1'b0;
      timer     <= '0;
      gate_open <= '0;
      timeout   <= 1'b0;
    end else if (run) begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (|req && !full) begin
            grant     <= pick;
            ptr       <= ~pick;
            gate_open <= pick ? 2'b10 : 2'b01;
            timer     <= '0;
            state     <= OPEN;
          end
        end
        OPEN: begin
          if (inc[grant]) begin
            gate_open <= '0;
            state     <= CLOSE;
          end else if (timer == T_LAST) begin
            gate_open <= '0;
            timeout   <= 1'b1;
            state     <= CLOSE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        CLOSE: begin
          timeout <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          gate_open <= '0;
          timeout   <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lot_controller.sv
// Directed plus randomized bench for lot_controller against a cycle-level
// behavioural model of the lot rules (CAPACITY=3, GATE_CYCLES=16).
module tb_lot_controller;

  localparam int CAP = 3;
  localparam int GC  = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] inc;
  logic       dec;
  logic       clear;
  logic [1:0] gate_open;
  logic [7:0] count;
  logic       full;
  logic       empty;
  logic       timeout;
  logic       err;

  int checks = 0;
  int errors = 0;
  int hi0, hi1, to_cnt;

  // model state: open lane (-1 when none), cycles the gate has been up,
  // one-cycle closing flag, preferred lane, occupancy, pulses
  int m_lane, m_age, m_pref, m_cnt;
  bit m_closing, m_to, m_err;

  lot_controller #(.CAPACITY(CAP), .CNT_W(8), .GATE_CYCLES(GC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .inc(inc), .dec(dec), .clear(clear),
    .gate_open(gate_open), .count(count), .full(full), .empty(empty),
    .timeout(timeout), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] m_gate();
    if (m_lane < 0) return 2'b00;
    return (m_lane == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic m_reset();
    m_lane = -1; m_age = 0; m_pref = 0; m_cnt = 0;
    m_closing = 0; m_to = 0; m_err = 0;
  endtask

  task automatic model_step(input logic [1:0] r, input logic [1:0] i,
                            input logic d, input logic c);
    logic [1:0] pg;
    bit pfull;
    int raw, cl;
    pg    = m_gate();
    pfull = (m_cnt == CAP);
    raw   = m_cnt + int'(i[0]) + int'(i[1]) - int'(d);
    if (c) begin
      m_cnt = 0;
      m_err = 0;
    end else begin
      cl    = (raw < 0) ? 0 : ((raw > CAP) ? CAP : raw);
      m_err = (cl != raw) || ((i & ~pg) != 2'b00);
      m_cnt = cl;
    end
    m_to = 0;
    if (m_closing) begin
      m_closing = 0;
    end else if (m_lane >= 0) begin
      if (i[m_lane]) begin
        m_lane = -1; m_closing = 1;
      end else if (m_age == GC) begin
        m_lane = -1; m_closing = 1; m_to = 1;
      end else begin
        m_age++;
      end
    end else if (r != 2'b00 && !pfull) begin
      m_lane = r[m_pref] ? m_pref : 1 - m_pref;
      m_pref = 1 - m_lane;
      m_age  = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("gate_open", 32'(gate_open), 32'(m_gate()));
    chk("count",     32'(count),     32'(m_cnt));
    chk("full",      32'(full),      32'(m_cnt == CAP));
    chk("empty",     32'(empty),     32'(m_cnt == 0));
    chk("timeout",   32'(timeout),   32'(m_to));
    chk("err",       32'(err),       32'(m_err));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_gate"},    32'(gate_open), 32'd0);
    chk({tag, "_count"},   32'(count),     32'd0);
    chk({tag, "_full"},    32'(full),      32'd0);
    chk({tag, "_empty"},   32'(empty),     32'd1);
    chk({tag, "_timeout"}, 32'(timeout),   32'd0);
    chk({tag, "_err"},     32'(err),       32'd0);
  endtask

  task automatic cyc(input logic [1:0] r, input logic [1:0] i,
                     input logic d, input logic c);
    req = r; inc = i; dec = d; clear = c;
    @(posedge clk);
    model_step(r, i, d, c);
    #1;
    check_all();
    if (gate_open[0]) hi0++;
    if (gate_open[1]) hi1++;
    if (timeout) to_cnt++;
    @(negedge clk);
  endtask

  // first edge after release must not act on a pending request
  task automatic release_reset();
    rst_n = 1'b1; req = 2'b01; inc = '0; dec = 1'b0; clear = 1'b0;
    @(posedge clk);
    #1;
    chk("sync_gate",  32'(gate_open), 32'd0);
    chk("sync_count", 32'(count),     32'd0);
    @(negedge clk);
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_reset();
  endtask

  initial begin
    rst_n = 1'b0; req = '0; inc = '0; dec = 1'b0; clear = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    reset_checks("por");
    release_reset();

    // arbitration: grants alternate 0,1,0,1 with req held
    for (int unsigned k = 0; k < 4; k++) begin
      cyc(2'b11, 2'b00, 1'b0, 1'b0);
      chk("arb_grant", 32'(gate_open), (k % 2 == 0) ? 32'd1 : 32'd2);
      cyc(2'b11, gate_open, 1'b0, 1'b0);
      chk("arb_closed", 32'(gate_open), 32'd0);
      cyc(2'b11, 2'b00, 1'b0, 1'b1);
    end
    cyc(2'b00, 2'b00, 1'b0, 1'b0);
    cyc(2'b00, 2'b00, 1'b0, 1'b0);

    // grant and entry on the third open cycle
    hi0 = 0;
    cyc(2'b01, 2'b00, 1'b0, 1'b0);
    cyc(2'b01, 2'b00, 1'b0, 1'b0);
    cyc(2'b01, 2'b00, 1'b0, 1'b0);
    cyc(2'b01, 2'b01, 1'b0, 1'b0);
    chk("entry_count", 32'(count), 32'd1);
    chk("entry_err",   32'(err),   32'd0);
    cyc(2'b00, 2'b00, 1'b0, 1'b0);
    chk("entry_high_cycles", 32'(hi0), 32'd3);
    cyc(2'b00, 2'b00, 1'b0, 1'b0);

    // timeout on lane 1 with req dropped after the grant
    hi1 = 0; to_cnt = 0;
    cyc(2'b10, 2'b00, 1'b0, 1'b0);
    repeat (19) cyc(2'b00, 2'b00, 1'b0, 1'b0);
    chk("timeout_high_cycles", 32'(hi1),    32'd16);
    chk("timeout_pulses",      32'(to_cnt), 32'd1);
    chk("timeout_count",       32'(count),  32'd1);

    // tailgate on lane 1 while lane 0 is open
    cyc(2'b01, 2'b00, 1'b0, 1'b0);
    cyc(2'b00, 2'b10, 1'b0, 1'b0);
    chk("tailgate_count", 32'(count), 32'd2);
    chk("tailgate_err",   32'(err),   32'd1);
    chk("tailgate_gate",  32'(gate_open), 32'd1);
    cyc(2'b00, 2'b01, 1'b0, 1'b0);
    cyc(2'b00, 2'b00, 1'b0, 1'b0);

    // saturation at CAPACITY, then full blocks new grants
    cyc(2'b00, 2'b11, 1'b1, 1'b0);
    chk("sat_count", 32'(count), 32'd3);
    chk("sat_err",   32'(err),   32'd1);
    chk("sat_full",  32'(full),  32'd1);
    hi0 = 0; hi1 = 0;
    repeat (6) cyc(2'b11, 2'b00, 1'b0, 1'b0);
    chk("full_no_grant", 32'(hi0 + hi1), 32'd0);

    // underflow and clear priority
    cyc(2'b00, 2'b00, 1'b0, 1'b1);
    cyc(2'b00, 2'b00, 1'b1, 1'b0);
    chk("under_count", 32'(count), 32'd0);
    chk("under_err",   32'(err),   32'd1);
    cyc(2'b00, 2'b01, 1'b0, 1'b0);
    cyc(2'b00, 2'b11, 1'b0, 1'b1);
    chk("clear_count", 32'(count), 32'd0);
    chk("clear_err",   32'(err),   32'd0);

    // reset asserted while a gate is open
    cyc(2'b01, 2'b00, 1'b0, 1'b0);
    cyc(2'b00, 2'b10, 1'b0, 1'b0);
    chk("pre_rst_gate", 32'(gate_open), 32'd1);
    rst_n = 1'b0;
    #1;
    reset_checks("mid_open_rst");
    m_reset();
    repeat (2) @(negedge clk);
    release_reset();
    cyc(2'b01, 2'b00, 1'b0, 1'b0);
    chk("post_rst_grant", 32'(gate_open), 32'd1);

    // randomized traffic
    for (int unsigned n = 0; n < 600; n++) begin
      logic [1:0] r, i;
      logic d, c;
      r = 2'($urandom_range(0, 3));
      i = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      d = ($urandom_range(0, 4) == 0);
      c = ($urandom_range(0, 19) == 0);
      cyc(r, i, d, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
